pc_unit: RTL
============

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter ADDR_W, default 32, width of all address ports and registers.
REQ-002 Parameter RESET_VEC, default 0, PC value after reset and while in IDLE.
REQ-003 Parameter EXC_VEC, default 'h180, PC loaded on exception.
REQ-004 Parameter INC, default 4, sequential increment.
REQ-005 Parameter RAS_DEPTH, default 4, return-address-stack entries, power of two ≥2.
REQ-006 Ports SHALL be:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  leave IDLE and begin fetching.
- halt  in  1  return to IDLE, PC held.
- stall  in  1  hold PC this cycle.
- redirect_valid  in  1  branch/jump taken.
- redirect_addr  in  ADDR_W  branch/jump target.
- exc_req  in  1  exception request.
- call_i  in  1  current instruction is a call; push return address.
- ret_i  in  1  current instruction is a return; pop predicted target.
- pc_o  out  ADDR_W  current PC.
- pc_plus_o  out  ADDR_W  pc_o+INC, combinational.
- epc_o  out  ADDR_W  PC captured at last exception.
- running_o  out  1  high in RUN.
- ras_empty_o  out  1  stack empty.
- ras_full_o  out  1  stack full.
- ras_err_o  out  1  sticky underflow/overflow flag.

Function
REQ-007 FSM SHALL have two states: IDLE and RUN.
REQ-008 IDLE->RUN on an edge with start=1; pc_o stays RESET_VEC on that edge, so the first fetch is RESET_VEC.
REQ-009 RUN->IDLE on an edge with halt=1 and exc_req=0; pc_o holds its value; halt SHALL outrank stall, redirect and ret.
REQ-010 In IDLE, every input except start SHALL be ignored.
REQ-011 In RUN, the next PC SHALL be selected by strict priority:
- exc_req: EXC_VEC.
- stall: hold.
- redirect_valid: redirect_addr.
- ret_i with stack non-empty: stack top.
- otherwise: pc_o+INC.
REQ-012 Every PC update SHALL take effect on the next rising edge (one-cycle latency); pc_o is a register.
REQ-013 redirect_addr and popped values SHALL have bits [1:0] forced to 0 when loaded.
REQ-014 pc_o+INC SHALL wrap modulo 2^ADDR_W with no flag.
REQ-015 On exception, epc_o SHALL load pc_o; the RAS SHALL be flushed to empty; exc_req SHALL override stall.
REQ-016 Push (pc_o+INC) on call_i SHALL occur only on edges where the PC advances (RUN, no exc, no stall, no halt).
REQ-017 Pop on ret_i SHALL follow the same condition as push.
REQ-018 Pop SHALL occur only if the stack is non-empty and redirect_valid=0.
REQ-019 Push when full SHALL overwrite the oldest entry (circular); count stays RAS_DEPTH; ras_err_o sets.
REQ-020 Pop when empty SHALL fall through to sequential; ras_err_o sets.
REQ-021 call_i and ret_i together SHALL pop first then push, so the top is replaced and count is unchanged.
REQ-022 ras_err_o SHALL clear only on reset.

Reset
REQ-023 rst=0 SHALL immediately, without a clock, set:
- pc_o=RESET_VEC.
- epc_o=0.
- FSM=IDLE, running_o=0.
- RAS empty (ras_empty_o=1, ras_full_o=0).
- ras_err_o=0.
REQ-024 Reset asserted mid-operation SHALL discard any pending redirect, push or pop.
REQ-025 Deassertion SHALL take effect at the next rising edge.

Configuration
REQ-026 Macro PC_UNIT_RAS_EN defined: RAS logic per REQ-016..REQ-022 present.
REQ-027 Macro undefined:
- no stack storage.
- call_i and ret_i ignored (ret never redirects).
- ras_empty_o=1, ras_full_o=0, ras_err_o=0 constants.
- all other behaviour identical.

Verification
REQ-028 Reset, start pulse, 3 free cycles -> pc_o 0,0,4,8,'hC.
REQ-029 At pc_o='h20: stall plus redirect_valid to 'h103 -> pc_o holds 'h20; drop stall -> pc_o='h100.
REQ-030 At pc_o='h40: exc_req with stall=1 -> pc_o='h180, epc_o='h40, ras_empty_o=1.
REQ-031 (RAS_EN) call at 'h10, 'h20, 'h30, 'h40, 'h50 -> full and ras_err_o=1; five ret -> targets 'h54,'h44,'h34,'h24, then sequential.
REQ-032 pc_o='hFFFF_FFFC, no events -> pc_o=0; rst low mid-cycle -> pc_o=0 and running_o=0 before the next edge.

Source files
------------

// File: rtl/pc_unit.sv
// ============================================================================
// pc_unit -- program counter sequencer with optional return-address stack
//
// Purpose
//   Holds the fetch PC and chooses its next value each cycle. A two-state FSM
//   (IDLE / RUN) gates fetching. In RUN the next PC is chosen by strict
//   priority: exception, stall (hold), redirect, predicted return, and
//   finally the sequential PC+INC. A small circular return-address stack
//   (RAS) predicts return targets.
//
// Configuration
//   PC_UNIT_RAS_EN  defined   : RAS storage and push/pop logic present.
//                   undefined : no RAS; call_i/ret_i ignored; RAS status
//                               outputs tied to empty / not full / no error.
//
// Parameters
//   ADDR_W     address width
//   RESET_VEC  PC after reset and first fetch address
//   EXC_VEC    PC loaded on exception
//   INC        sequential increment
//   RAS_DEPTH  RAS entries (power of two, >= 2)
//
// Ports
//   clk            in   clock, rising edge
//   rst            in   asynchronous active-low reset
//   start          in   IDLE -> RUN
//   halt           in   RUN -> IDLE, PC held
//   stall          in   hold PC this cycle
//   redirect_valid in   branch/jump taken
//   redirect_addr  in   branch/jump target (low two bits dropped)
//   exc_req        in   exception request
//   call_i         in   call: push PC+INC
//   ret_i          in   return: pop predicted target
//   pc_o           out  current PC (registered)
//   pc_plus_o      out  pc_o + INC (combinational, wraps)
//   epc_o          out  PC captured at last exception
//   running_o      out  high in RUN
//   ras_empty_o    out  RAS empty
//   ras_full_o     out  RAS full
//   ras_err_o      out  sticky RAS underflow/overflow
// ============================================================================
module pc_unit #(
    parameter int unsigned        ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]  RESET_VEC = '0,
    parameter logic [ADDR_W-1:0]  EXC_VEC   = 'h180,
    parameter int unsigned        INC       = 4,
    parameter int unsigned        RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              halt,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    input  logic              exc_req,
    input  logic              call_i,
    input  logic              ret_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] pc_plus_o,
    output logic [ADDR_W-1:0] epc_o,
    output logic              running_o,
    output logic              ras_empty_o,
    output logic              ras_full_o,
    output logic              ras_err_o
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] epc_q, epc_d;
    logic [ADDR_W-1:0] pc_plus;

    // advance: the PC moves this edge (RUN, no exception, no halt, no stall);
    // stack pushes/pops are only allowed on such edges.
    logic              advance;
    logic              take_exc;

    // RAS view used by the PC mux; driven by either build of the stack.
    logic              ras_empty;
    logic              ras_full;
    logic              ras_err;
    logic [ADDR_W-1:0] ras_top;

    // Instruction addresses are word aligned: drop the two low bits.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:2], 2'b00};
    endfunction

    assign pc_plus = pc_q + ADDR_W'(INC);

    // ------------------------------------------------------------------
    // FSM state and PC registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_VEC;
            epc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state / next-PC selection
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        epc_d    = epc_q;
        advance  = 1'b0;
        take_exc = 1'b0;

        case (state_q)
            IDLE: begin
                // The start edge itself does not move the PC, so the first
                // fetch in RUN is the value held here.
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (exc_req) begin
                    // Exception outranks halt and stall.
                    take_exc = 1'b1;
                    pc_d     = EXC_VEC;
                    epc_d    = pc_q;
                end else if (halt) begin
                    state_d = IDLE;
                end else if (stall) begin
                    pc_d = pc_q;
                end else begin
                    advance = 1'b1;
                    if (redirect_valid) begin
                        pc_d = word_align(redirect_addr);
                    end else if (ret_i && !ras_empty) begin
                        pc_d = word_align(ras_top);
                    end else begin
                        pc_d = pc_plus;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef PC_UNIT_RAS_EN
    // ------------------------------------------------------------------
    // Return-address stack: circular buffer addressed by a top pointer.
    // A push when full simply advances the pointer onto the oldest slot,
    // which is what makes overflow overwrite the oldest entry.
    // ------------------------------------------------------------------
    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  top_q, top_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              wr_en;
    logic [PTR_W-1:0]  wr_ptr;
    logic              do_push;
    logic              do_pop;
    logic              underflow;
    logic              overflow;

    assign ras_empty = (cnt_q == '0);
    assign ras_full  = (cnt_q == CNT_W'(RAS_DEPTH));
    assign ras_err   = err_q;
    assign ras_top   = ras_mem[top_q];

    // A redirect suppresses the pop (its target wins), but never the push.
    assign do_pop    = advance && ret_i && !redirect_valid && !ras_empty;
    assign underflow = advance && ret_i && !redirect_valid &&  ras_empty;
    assign do_push   = advance && call_i;
    // With a simultaneous pop the push reuses the freed slot: no overflow.
    assign overflow  = do_push && !do_pop && ras_full;

    always_comb begin
        top_d  = top_q;
        cnt_d  = cnt_q;
        err_d  = err_q;
        wr_en  = 1'b0;
        wr_ptr = top_q;

        if (take_exc) begin
            cnt_d = '0;
        end else begin
            if (do_pop && do_push) begin
                // Pop then push: overwrite the top in place.
                wr_en  = 1'b1;
                wr_ptr = top_q;
            end else if (do_pop) begin
                top_d = top_q - PTR_W'(1);
                cnt_d = cnt_q - CNT_W'(1);
            end else if (do_push) begin
                top_d  = top_q + PTR_W'(1);
                wr_en  = 1'b1;
                wr_ptr = top_q + PTR_W'(1);
                if (!ras_full) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            if (underflow || overflow) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            top_q <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            top_q <= top_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // Entry storage needs no reset: the count alone defines validity.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            ras_mem[wr_ptr] <= pc_plus;
        end
    end
`else
    // No stack: return never predicts, status outputs are constant.
    assign ras_empty = 1'b1;
    assign ras_full  = 1'b0;
    assign ras_err   = 1'b0;
    assign ras_top   = '0;

    logic ras_unused;
    assign ras_unused = ^{advance, take_exc, call_i, ret_i};
`endif

    assign pc_o        = pc_q;
    assign pc_plus_o   = pc_plus;
    assign epc_o       = epc_q;
    assign running_o   = (state_q == RUN);
    assign ras_empty_o = ras_empty;
    assign ras_full_o  = ras_full;
    assign ras_err_o   = ras_err;

endmodule
